// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with a fixed, parameterised access latency.
// A single load or store is accepted in IDLE, the pipeline is frozen through
// BUSY while a down-counter expires, and the access is committed on the last
// BUSY cycle. DONE then pulses done_o for one cycle. Malformed requests are
// rejected with a one-cycle err_o pulse and never stall the pipeline.
//
// State table:
//   IDLE | waiting for a request; a valid one raises stall_o in the same cycle
//   BUSY | latency countdown in cnt_q; access commits when cnt_q reaches 0
//   DONE | access finished; done_o=1, stall_o=0, request inputs ignored
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   MemRead_i    load request
//   MemWrite_i   store request
//   addr_i       byte address (word aligned, word index < DEPTH)
//   WriteData_i  store data
//   ReadData_o   registered load data, held until the next completed load
//   stall_o      pipeline freeze request
//   done_o       one-cycle completion pulse
//   err_o        one-cycle pulse, the cycle after a rejected request
module dmem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            op_wr_q;
  logic [AW-1:0]   word_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];

  logic any_req, one_req, addr_ok, req_valid;
  logic capture, access, err_d;

  assign any_req   = MemRead_i | MemWrite_i;
  assign one_req   = MemRead_i ^ MemWrite_i;
  assign addr_ok   = (addr_i[1:0] == 2'b00) && ({2'b00, addr_i[31:2]} < 32'(DEPTH));
  assign req_valid = one_req && addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    capture = 1'b0;
    access  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (req_valid) begin
            capture = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
            stall_o = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The pipeline must never be frozen while reset is asserted.
    if (rst_i) stall_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ReadData_o <= 32'd0;
      err_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_o   <= err_d;
      if (capture) begin
        op_wr_q <= MemWrite_i;
        word_q  <= addr_i[AW+1:2];
        wdata_q <= WriteData_i;
      end
      if (access && !op_wr_q) ReadData_o <= mem[word_q];
    end
  end

  // Array has no reset; a write only lands on the final BUSY cycle, so a
  // reset earlier in BUSY leaves the contents untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access && op_wr_q) mem[word_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, err;
  logic        b_rd, b_wr;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_stall, b_done, b_err;

  dmem_ctrl #(.DEPTH(256), .LATENCY(3)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .WriteData_i(wdata), .ReadData_o(rdata),
    .stall_o(stall), .done_o(done), .err_o(err)
  );

  dmem_ctrl #(.DEPTH(256), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(b_rd), .MemWrite_i(b_wr),
    .addr_i(b_addr), .WriteData_i(b_wdata), .ReadData_o(b_rdata),
    .stall_o(b_stall), .done_o(b_done), .err_o(b_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mem_model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got=0x%08h with empty scoreboard", tag, got);
    end else begin
      e = exp_q.pop_front();
      chk(tag, got, e);
      last_rd = e;
    end
  endtask

  // One LATENCY=3 access on u_dut. Inputs are scrambled during BUSY and left
  // scrambled in DONE; neither may have any effect.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    bit valid;
    valid = (r ^ w) && (a[1:0] == 2'b00) && (a[31:2] < 30'd256);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    if (valid) begin
      chk("stall_req_cycle", stall, 1);
      if (r) exp_q.push_back(mem_model[int'(a[31:2])]);
      if (w) mem_model[int'(a[31:2])] = d;
      for (int k = 1; k <= 3; k++) begin
        tick();
        chk("stall_busy", stall, 1);
        chk("done_busy", done, 0);
        chk("err_busy", err, 0);
        rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
        addr = $urandom; wdata = $urandom;
      end
      tick();
      chk("done_pulse", done, 1);
      chk("stall_done", stall, 0);
      chk("err_done", err, 0);
      if (r) pop_chk("read_data", rdata);
      else   chk("rdata_hold_wr", rdata, last_rd);
      rd = 1'b0; wr = 1'b0;
      tick();
      chk("done_once", done, 0);
      chk("stall_idle", stall, 0);
      chk("err_after_done", err, 0);
    end else begin
      chk("stall_bad_req", stall, 0);
      tick();
      rd = 1'b0; wr = 1'b0;
      #1;
      chk("err_pulse", err, 1);
      chk("stall_after_bad", stall, 0);
      chk("rdata_hold_bad", rdata, last_rd);
      tick();
      chk("err_once", err, 0);
      chk("done_after_bad", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_stall;
    logic [31:0] a;
    logic [31:0] d;
    last_rd = 32'd0;
    rst_i = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    tick();
    tick();
    // A valid request under reset must not freeze the pipeline.
    rd = 1'b1; addr = 32'h10;
    #1;
    chk("stall_in_reset", stall, 0);
    rd = 1'b0;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    tick();
    chk("idle_stall", stall, 0);

    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    do_access(1'b1, 1'b0, 32'h13, 32'h0);
    do_access(1'b1, 1'b0, 32'h400, 32'h0);
    do_access(1'b0, 1'b1, 32'h8, 32'h12345678);
    do_access(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
    do_access(1'b1, 1'b0, 32'h8, 32'h0);
    do_access(1'b0, 1'b1, 32'h3FC, 32'hA5A55A5A);
    do_access(1'b1, 1'b0, 32'h3FC, 32'h0);
    do_access(1'b0, 1'b1, 32'h3FE, 32'h0);

    for (int i = 0; i < 6; i++) begin
      a = 32'h40 + 32'(4 * $urandom_range(0, 3));
      d = $urandom;
      do_access(1'b0, 1'b1, a, d);
      do_access(1'b1, 1'b0, a, 32'h0);
    end

    // Read held high through DONE: one done pulse, then a fresh access.
    rd = 1'b1; wr = 1'b0; addr = 32'h10;
    #1;
    chk("held_stall0", stall, 1);
    exp_q.push_back(mem_model[4]);
    exp_q.push_back(mem_model[4]);
    repeat (3) tick();
    tick();
    chk("held_done1", done, 1);
    chk("held_err", err, 0);
    pop_chk("held_rdata1", rdata);
    tick();
    chk("held_done_once", done, 0);
    chk("held_restart", stall, 1);
    tick();
    rd = 1'b0;
    tick();
    tick();
    tick();
    chk("held_done2", done, 1);
    pop_chk("held_rdata2", rdata);
    tick();
    chk("held_idle_stall", stall, 0);
    chk("held_idle_done", done, 0);

    // Reset in the second BUSY cycle of a write aborts it.
    do_access(1'b0, 1'b1, 32'h20, 32'h1);
    wr = 1'b1; addr = 32'h20; wdata = 32'h2;
    #1;
    tick();
    wr = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("stall_rst_busy", stall, 0);
    tick();
    rst_i = 1'b0;
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_done", done, 0);
    chk("abort_stall", stall, 0);
    last_rd = 32'd0;
    tick();
    do_access(1'b1, 1'b0, 32'h20, 32'h0);

    // LATENCY=1 instance: write then read word 0x4.
    b_wr = 1'b1; b_addr = 32'h4; b_wdata = 32'hCAFEF00D;
    #1;
    n_stall = 0;
    for (int k = 0; k < 8 && !b_done; k++) begin
      if (b_stall) n_stall++;
      tick();
      b_wr = 1'b0;
    end
    chk("l1_wr_done", b_done, 1);
    chk("l1_wr_stall_cycles", n_stall, 2);
    tick();
    b_rd = 1'b1; b_addr = 32'h4;
    #1;
    chk("l1_stall_c1", b_stall, 1);
    tick();
    b_rd = 1'b0;
    chk("l1_stall_c2", b_stall, 1);
    chk("l1_done_c2", b_done, 0);
    tick();
    chk("l1_done_c3", b_done, 1);
    chk("l1_stall_c3", b_stall, 0);
    chk("l1_rdata", b_rdata, 32'hCAFEF00D);
    chk("l1_err", b_err, 0);
    tick();
    chk("l1_done_once", b_done, 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the internal data array (power of two).
REQ-002 Parameter LATENCY, default 3: access latency in cycles; legal range 1..15.
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port MemRead_i, input, 1: load request from the EX/MEM pipeline register.
REQ-006 Port MemWrite_i, input, 1: store request from the EX/MEM pipeline register.
REQ-007 Port addr_i, input, 32: byte address from the ALU result.
REQ-008 Port WriteData_i, input, 32: store data.
REQ-009 Port ReadData_o, output, 32: load data, registered, feeds the MEM/WB register.
REQ-010 Port stall_o, output, 1: freeze request to PC/IF_ID/ID_EX/EX_MEM/MEM_WB.
REQ-011 Port done_o, output, 1: one-cycle pulse on access completion.
REQ-012 Port err_o, output, 1: one-cycle pulse on a rejected request.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE, with a 4-bit down-counter cnt.
REQ-014 A request is exactly one of MemRead_i or MemWrite_i high, sampled only in IDLE.
REQ-015 A request is valid when addr_i[1:0]==0 and addr_i[31:2] < DEPTH.
REQ-016 IDLE with a valid request SHALL capture op, addr_i[31:2] and WriteData_i, load cnt=LATENCY-1, go to BUSY, and drive stall_o=1 combinationally in that same cycle.
REQ-017 BUSY SHALL hold stall_o=1 and decrement cnt each cycle.
REQ-018 When cnt==0 in BUSY, the block SHALL perform the access and go to DONE.
REQ-019 The access SHALL be either a write of the captured data into the array, or a load of array[word] into ReadData_o.
REQ-020 DONE SHALL drive stall_o=0 and done_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-021 In DONE the request inputs are ignored; the still-present request SHALL NOT retrigger.
REQ-022 Total stall_o-high cycles per access SHALL be LATENCY+1; done_o SHALL assert LATENCY+1 cycles after the request cycle.
REQ-023 In IDLE, an invalid request (misaligned, out of range, or both MemRead_i and MemWrite_i high) SHALL keep stall_o=0, perform no access, and pulse err_o for one cycle on the next cycle.
REQ-024 err_o SHALL NOT fire while the request inputs are ignored in DONE.
REQ-025 ReadData_o SHALL hold its value until the next completed read; writes and rejected requests SHALL NOT change it.
REQ-026 Inputs changing during BUSY SHALL have no effect (captured copies only).
REQ-027 With no request in IDLE, stall_o=0, done_o=0 and err_o=0.

Reset
REQ-028 With rst_i high at a clock edge, the block SHALL return to IDLE with cnt=0, ReadData_o=0, done_o=0 and err_o=0.
REQ-029 stall_o SHALL be 0 in any cycle where rst_i is high.
REQ-030 Reset SHALL NOT initialize the data array; contents are undefined until written.
REQ-031 Reset during BUSY SHALL abort the access; a write not yet committed (cnt!=0) SHALL NOT modify the array.

Verification
REQ-032 LATENCY=3, write addr 0x10 data 0xDEADBEEF at cycle 0 -> stall_o=1 in cycles 0-3, done_o=1 in cycle 4, then read 0x10 -> ReadData_o=0xDEADBEEF with done_o.
REQ-033 Read addr 0x13 (misaligned), and separately addr 0x400 with DEPTH=256 -> stall_o stays 0, err_o pulses the next cycle, ReadData_o unchanged.
REQ-034 MemRead_i and MemWrite_i both high at addr 0x8 -> err_o pulse, no stall, word 0x8 unchanged on a later read.
REQ-035 Request held high through DONE -> exactly one done_o pulse, then a new access starts on the following IDLE cycle only if the request is still asserted.
REQ-036 Write 0x1 to 0x20, then write 0x2 to 0x20 with rst_i asserted in the second BUSY cycle -> a subsequent read of 0x20 returns 0x1, and ReadData_o is 0 immediately after reset.
REQ-037 LATENCY=1 build, read of 0x4 -> stall_o high for exactly 2 cycles, done_o in the third cycle.
